// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port
// between instruction fetch and data load/store, with wait-state timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic G_IF = 1'b0;
  localparam logic G_D  = 1'b1;

  logic [1:0]        state;
  logic              gnt;
  logic              last_grant;
  logic [CW-1:0]     cnt;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic pick_d;
  logic expire;
  logic done;

  // data wins when fetch is idle or fetch had the last turn
  always_comb begin
    pick_d = d_req & (~if_req | (last_grant == G_IF));
    expire = (TIMEOUT != 0) && (cnt == CNT_LAST);
    done   = mem_ready | expire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gnt        <= G_IF;
      last_grant <= G_D;
      cnt        <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_req | d_req) begin
            gnt        <= pick_d;
            last_grant <= pick_d;
            mem_addr   <= pick_d ? d_addr : if_addr;
            mem_we     <= pick_d & d_we;
            mem_wdata  <= pick_d ? d_wdata : '0;
            cnt        <= '0;
            mem_en     <= 1'b1;
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (done) begin
            // ready takes priority over an expiring counter
            rdata_q <= mem_ready ? mem_rdata : '0;
            err_q   <= ~mem_ready;
            mem_en  <= 1'b0;
            if_ack  <= (gnt == G_IF);
            d_ack   <= (gnt == G_D);
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

  assign if_err   = if_ack & err_q;
  assign d_err    = d_ack & err_q;
  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses against
// a wait-state memory model; acks are checked by a separate monitor.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_err(if_err),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ready after ws wait states, never if ws < 0
  int          ws  = 0;
  int          acc = 0;
  logic [15:0] rdata_v = 16'h0000;
  always @(posedge clk) acc <= mem_en ? acc + 1 : 0;
  assign mem_ready = mem_en && (ws >= 0) && (acc == ws);
  assign mem_rdata = rdata_v;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_d;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  function automatic void push(bit p, bit e, bit cd,
                               logic [15:0] d, int c);
    exp_t x;
    x.port  = p;
    x.err   = e;
    x.chk_d = cd;
    x.data  = d;
    x.cyc   = c;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (if_ack || d_ack) begin
      chk("one_ack", 32'(if_ack & d_ack), 32'd0);
      chk("ack_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", 32'(d_ack), 32'(e.port));
        chk("ack_err", 32'(d_ack ? d_err : if_err),
            32'(e.err));
        if (e.chk_d)
          chk("ack_data",
              32'(d_ack ? d_rdata : if_rdata),
              32'(e.data));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{if_ack, if_err, if_rdata, d_ack, d_err,
             d_rdata, mem_en, mem_we, mem_addr,
             mem_wdata, busy};
  endfunction

  int t0;

  initial begin
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(any_out()), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // single fetch, zero wait
    next_cycle();
    t0 = cyc; ws = 0; rdata_v = 16'hBEEF;
    if_req = 1'b1; if_addr = 16'h0010;
    push(1'b0, 1'b0, 1'b1, 16'hBEEF, t0 + 2);
    @(negedge clk);
    chk("f_c0_en", 32'(mem_en), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("f_c1_en", 32'(mem_en), 32'd1);
    chk("f_c1_addr", 32'(mem_addr), 32'h0010);
    chk("f_c1_we", 32'(mem_we), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("f_c2_ack", 32'(if_ack), 32'd1);
    next_cycle();
    if_req = 1'b0;

    // store, 3 wait states
    next_cycle();
    t0 = cyc; ws = 3; rdata_v = 16'hDEAD;
    d_req = 1'b1; d_we = 1'b1;
    d_addr = 16'h0200; d_wdata = 16'h1234;
    push(1'b1, 1'b0, 1'b0, 16'h0000, t0 + 5);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("st_en", 32'(mem_en), 32'd1);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_wdata", 32'(mem_wdata), 32'h1234);
      chk("st_addr", 32'(mem_addr), 32'h0200);
      chk("st_busy", 32'(busy), 32'd1);
    end
    next_cycle();
    @(negedge clk);
    chk("st_c5_busy", 32'(busy), 32'd1);
    chk("st_c5_en", 32'(mem_en), 32'd0);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("st_c6_busy", 32'(busy), 32'd0);

    // timeout on a load
    next_cycle();
    t0 = cyc; ws = -1; rdata_v = 16'h9999;
    d_req = 1'b1; d_addr = 16'h0300;
    push(1'b1, 1'b1, 1'b1, 16'h0000, t0 + 5);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("to_en", 32'(mem_en), 32'd1);
    end
    next_cycle();
    @(negedge clk);
    chk("to_c5_en", 32'(mem_en), 32'd0);
    next_cycle();
    d_req = 1'b0;

    // ready on the last allowed cycle beats timeout
    next_cycle();
    t0 = cyc; ws = 3; rdata_v = 16'hCAFE;
    d_req = 1'b1; d_addr = 16'h0304;
    push(1'b1, 1'b0, 1'b1, 16'hCAFE, t0 + 5);
    repeat (6) next_cycle();
    d_req = 1'b0;

    // contention from reset
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    next_cycle();
    t0 = cyc; ws = 0; rdata_v = 16'h5A5A;
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_addr = 16'h0400;
    push(1'b0, 1'b0, 1'b1, 16'h5A5A, t0 + 2);
    push(1'b1, 1'b0, 1'b1, 16'h5A5A, t0 + 5);
    push(1'b0, 1'b0, 1'b1, 16'h5A5A, t0 + 8);
    push(1'b1, 1'b0, 1'b1, 16'h5A5A, t0 + 11);
    next_cycle();
    @(negedge clk);
    chk("ct_c1_addr", 32'(mem_addr), 32'h0100);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("ct_c4_addr", 32'(mem_addr), 32'h0400);
    repeat (8) next_cycle();
    if_req = 1'b0; d_req = 1'b0;

    // reset in the middle of a slow fetch
    next_cycle();
    t0 = cyc; ws = 5;
    if_req = 1'b1; if_addr = 16'h0040;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_c2_en", 32'(mem_en), 32'd1);
    next_cycle();
    d_req = 1'b1; d_addr = 16'h0050;
    @(negedge clk);
    chk("rm_c3_zero", 32'(any_out()), 32'd0);
    next_cycle();
    rst_n = 1'b1; ws = 0; rdata_v = 16'h7777;
    t0 = cyc;
    push(1'b0, 1'b0, 1'b1, 16'h7777, t0 + 2);
    push(1'b1, 1'b0, 1'b1, 16'h7777, t0 + 5);
    @(negedge clk);
    chk("rm_c4_en", 32'(mem_en), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rm_c5_addr", 32'(mem_addr), 32'h0040);
    next_cycle();
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rm_c8_addr", 32'(mem_addr), 32'h0050);
    repeat (2) next_cycle();
    d_req = 1'b0;

    repeat (4) next_cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
